fc_func_pipe: RTL
=================

Name: fc_func_pipe

Overview:
- Next-generation function unit between the CIM output buffers and the next MLP layer's input buffer.
- Sweeps obuf addresses with a configurable read latency.
- Sums partial results across vertical CIM tiles as signed values.
- Applies ReLU, runtime right-shift requantisation and saturation to DATA_SIZE.
- Writes results with per-channel valid masking, then pulses start to the next layer.

Parameters:
- DATA_SIZE, 8, output activation width.
- XBAR_SIZE, 256, crossbar rows/cols.
- OBUF_DATA_SIZE, 2*DATA_SIZE+$clog2(XBAR_SIZE), width of one obuf element; two's complement.
- H_CIM_TILES, 16, horizontal tiles of this layer.
- V_CIM_TILES, 1, vertical tiles of this layer; must be >= 1.
- NUM_CHANNELS, 2, elements read per address per tile.
- ELEMENTS_PER_TILE, XBAR_SIZE/DATA_SIZE, valid elements per tile.
- NUM_ADDR, ceil(ELEMENTS_PER_TILE/NUM_CHANNELS), obuf addresses swept.
- RD_LATENCY, 1, cycles from o_addr to valid i_data (0..4).
- ACC_W, OBUF_DATA_SIZE+$clog2(V_CIM_TILES)+1, accumulator width.
- AW, max(1,$clog2(NUM_ADDR)), address width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- i_start  input  1  previous stage requests processing.
- o_ready  output  1  high when idle with no pending start.
- i_cim_ready  input  1  CIM obuf contents valid.
- i_data  input  [OBUF_DATA_SIZE] x [H][NUM_CHANNELS][V]  obuf read data.
- o_addr  output  AW  obuf read address.
- i_shift  input  $clog2(ACC_W)  requant right-shift; sampled at start acceptance.
- o_data  output  [DATA_SIZE] x [H][NUM_CHANNELS]  activations to next input buffer.
- o_waddr  output  AW  write address for o_data.
- o_wmask  output  NUM_CHANNELS  per-channel write valid.
- o_write_enable  output  1  write strobe.
- i_next_ready  input  1  next layer can accept a full sweep.
- o_start  output  1  one-cycle pulse: sweep complete.

Behaviour:
- Reset (rst=0, async) clears everything:
  - state=S_IDLE; o_ready=1 after release.
  - o_addr, o_waddr, o_data, o_wmask, o_write_enable, o_start all 0.
  - pending flag, shift register and valid pipeline cleared.
- Reset mid-sweep aborts the sweep; no o_start is produced.
- States:
  - S_IDLE: o_ready=1. On i_start:
    - if i_cim_ready && i_next_ready → latch i_shift, go to S_ISSUE.
    - else set pending and go to S_WAIT.
  - S_WAIT: o_ready=0. Go to S_ISSUE (latching i_shift) in the first cycle where i_cim_ready && i_next_ready. Further i_start pulses are ignored.
  - S_ISSUE: o_addr = 0..NUM_ADDR-1, one per cycle; no stalls. After NUM_ADDR-1 is issued → S_DRAIN.
  - S_DRAIN: wait until the valid pipeline is empty → S_DONE.
  - S_DONE: o_start=1 for exactly one cycle → S_IDLE.
- i_start is ignored outside S_IDLE. o_ready=0 in every state except S_IDLE.
- Pipeline:
  - Issued address is delayed RD_LATENCY cycles, then i_data is captured.
  - Accumulate/activate stage is registered.
  - Result: o_write_enable/o_data/o_waddr appear RD_LATENCY+1 cycles after the address.
  - RD_LATENCY=0 means i_data is combinational on o_addr in the same cycle.
- Timing, with start accepted at the clk edge ending cycle T:
  - addr 0 in T+1.
  - First write in T+RD_LATENCY+2.
  - Last write in T+NUM_ADDR+RD_LATENCY+1.
  - o_start in T+NUM_ADDR+RD_LATENCY+2.
  - o_ready high from T+NUM_ADDR+RD_LATENCY+3.
- Arithmetic, per (h,c):
  - acc = Σ_k sign-extended i_data[h][c][k] in ACC_W bits. No overflow is possible by construction.
  - If acc<0 → 0.
  - Else q = acc >>> shift (arithmetic); if q > 2^DATA_SIZE-1 → 2^DATA_SIZE-1; else q[DATA_SIZE-1:0].
- Mask: o_wmask[c] = (o_waddr*NUM_CHANNELS+c < ELEMENTS_PER_TILE). Masked channels drive o_data=0.
- o_data/o_waddr/o_wmask hold their last values when o_write_enable=0.

Optional Feature:
- Macro: FC_FUNC_PIPE_ROUND_EN.
- Defined: round-half-up before the shift, q = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift. Addition is done in ACC_W+1 bits, then saturated.
- Undefined: truncating shift. Port list is identical either way.

Decomposition:
- fc_func_pkg holds:
  - the t_fc_func_pipe_state enum (S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_DONE);
  - a safe_clog2 function (returns >=1);
  - a saturate function.
- One sub-module, fc_func_act: pure combinational accumulate + ReLU + shift/round + saturate for one (h,c) lane.
  - Parameters: DATA_SIZE, OBUF_DATA_SIZE, V_CIM_TILES, ACC_W.
  - Instantiated H×NUM_CHANNELS times; the output register lives in the parent.

Test Plan:
- Basic sweep:
  - Setup: H=1, V=1, NUM_CHANNELS=2, XBAR_SIZE=256, DATA_SIZE=8, RD_LATENCY=1, shift=0, i_data=addr.
  - Stimulus: start with both readies high.
  - Expected: 16 writes, waddr 0..15, o_start 1 cycle after the last write, o_ready back high.
- Vertical sum, ReLU and saturation:
  - Setup: V=2.
  - Stimulus: tile values (100,-150), then (200,100), then shift=1 on (300,300).
  - Expected: data 0; 255 (300 saturates); 255 (600>>1=300 saturates).
- Pending start:
  - Stimulus: i_start pulse with i_next_ready=0; raise i_next_ready 5 cycles later.
  - Expected: o_ready=0 throughout; addr 0 appears the cycle after i_next_ready rises; exactly one sweep and one o_start.
- Partial last address:
  - Setup: ELEMENTS_PER_TILE=32, NUM_CHANNELS=3, so NUM_ADDR=11.
  - Expected: at waddr 10, o_wmask=3'b011 and channel 2 data=0.
- Async reset mid-sweep:
  - Stimulus: assert rst=0 between clock edges while at addr 5.
  - Expected: outputs zero immediately, no o_start, next start begins at addr 0.
- FC_FUNC_PIPE_ROUND_EN:
  - Stimulus: acc=5, shift=1.
  - Expected: 3 with the macro defined, 2 without.

Source files
------------

// File: rtl/fc_func_pkg.sv
// Shared types and helpers for the fc_func_pipe function unit.
// Holds the sweep FSM state encoding, a clog2 that never returns 0, and an unsigned clamp.
package fc_func_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } t_fc_func_pipe_state;

    function automatic int safe_clog2(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Clamp a signed value into [0, 2^width-1].
    function automatic logic [63:0] saturate(input logic signed [63:0] val, input int width);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< width) - 64'sd1;
        if (val < 64'sd0) begin
            return 64'd0;
        end else if (val > max_v) begin
            return max_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/fc_func_act.sv
// One (h,c) lane: vertical tile sum, ReLU, right-shift requantisation and saturation.
// FC_FUNC_PIPE_ROUND_EN selects round-half-up before the shift; otherwise the shift truncates.
module fc_func_act
    import fc_func_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int OBUF_DATA_SIZE = 24,
    parameter int V_CIM_TILES    = 1,
    parameter int ACC_W          = OBUF_DATA_SIZE + $clog2(V_CIM_TILES) + 1,
    localparam int SHIFT_W       = safe_clog2(ACC_W)
) (
    input  logic [V_CIM_TILES-1:0][OBUF_DATA_SIZE-1:0] i_data,
    input  logic [SHIFT_W-1:0]                         i_shift,
    output logic [DATA_SIZE-1:0]                       o_act
);

    localparam int EXT_W = ACC_W + 1;

    logic signed [ACC_W-1:0] acc_s;
    logic signed [EXT_W-1:0] ext_s;
    logic signed [EXT_W-1:0] rnd_s;
    logic signed [EXT_W-1:0] q_s;

    // Sum sign-extended tiles, optionally add the rounding half, shift and clamp.
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < V_CIM_TILES; k++) begin
            acc_s = acc_s + {{(ACC_W-OBUF_DATA_SIZE){i_data[k][OBUF_DATA_SIZE-1]}}, i_data[k]};
        end
        ext_s = {acc_s[ACC_W-1], acc_s};
`ifdef FC_FUNC_PIPE_ROUND_EN
        if (i_shift != '0) begin
            rnd_s = EXT_W'(1) << (i_shift - SHIFT_W'(1));
        end else begin
            rnd_s = '0;
        end
`else
        rnd_s = '0;
`endif
        q_s = (ext_s + rnd_s) >>> i_shift;
        if (acc_s[ACC_W-1]) begin
            o_act = '0;
        end else begin
            o_act = DATA_SIZE'(saturate(64'(q_s), DATA_SIZE));
        end
    end

endmodule

// File: rtl/fc_func_pipe.sv
// Function unit between CIM obuf and next-layer input buffer: sweeps obuf, activates, writes, pulses start.
// Build with FC_FUNC_PIPE_ROUND_EN for round-half-up requantisation (see fc_func_act).
module fc_func_pipe
    import fc_func_pkg::*;
#(
    parameter int DATA_SIZE         = 8,
    parameter int XBAR_SIZE         = 256,
    parameter int OBUF_DATA_SIZE    = 2*DATA_SIZE + $clog2(XBAR_SIZE),
    parameter int H_CIM_TILES       = 16,
    parameter int V_CIM_TILES       = 1,
    parameter int NUM_CHANNELS      = 2,
    parameter int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE,
    parameter int NUM_ADDR          = (ELEMENTS_PER_TILE + NUM_CHANNELS - 1) / NUM_CHANNELS,
    parameter int RD_LATENCY        = 1,
    parameter int ACC_W             = OBUF_DATA_SIZE + $clog2(V_CIM_TILES) + 1,
    parameter int AW                = safe_clog2(NUM_ADDR)
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic                                                          i_start,
    output logic                                                          o_ready,
    input  logic                                                          i_cim_ready,
    input  logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][V_CIM_TILES-1:0][OBUF_DATA_SIZE-1:0] i_data,
    output logic [AW-1:0]                                                 o_addr,
    input  logic [$clog2(ACC_W)-1:0]                                      i_shift,
    output logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0]       o_data,
    output logic [AW-1:0]                                                 o_waddr,
    output logic [NUM_CHANNELS-1:0]                                       o_wmask,
    output logic                                                          o_write_enable,
    input  logic                                                          i_next_ready,
    output logic                                                          o_start
);

    localparam int SHIFT_W = $clog2(ACC_W);

    t_fc_func_pipe_state state_q;
    logic                pend_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic [AW-1:0]       addr_q;
    logic                ready_q;
    logic                start_q;
    logic                we_q;
    logic [AW-1:0]       waddr_q;
    logic [NUM_CHANNELS-1:0] wmask_q;
    logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] data_q;

    logic                issue_s;
    logic                cap_vld_s;
    logic [AW-1:0]       cap_addr_s;
    logic                inflight_s;
    logic [NUM_CHANNELS-1:0] wmask_d;
    logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] act_s;
    logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] data_d;

    assign issue_s = (state_q == S_ISSUE);

    // The capture point is where i_data belongs to the address issued RD_LATENCY cycles earlier.
    if (RD_LATENCY == 0) begin : g_rd0
        assign cap_vld_s  = issue_s;
        assign cap_addr_s = addr_q;
        assign inflight_s = 1'b0;
    end else begin : g_rdn
        logic [RD_LATENCY-1:0]         vld_dly_q;
        logic [RD_LATENCY-1:0][AW-1:0] addr_dly_q;

        // Delay line carrying issued addresses until their read data returns.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_dly_q  <= '0;
                addr_dly_q <= '0;
            end else begin
                vld_dly_q[0]  <= issue_s;
                addr_dly_q[0] <= addr_q;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    vld_dly_q[i]  <= vld_dly_q[i-1];
                    addr_dly_q[i] <= addr_dly_q[i-1];
                end
            end
        end

        assign cap_vld_s  = vld_dly_q[RD_LATENCY-1];
        assign cap_addr_s = addr_dly_q[RD_LATENCY-1];
        assign inflight_s = |vld_dly_q;
    end

    for (genvar h = 0; h < H_CIM_TILES; h++) begin : g_h
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_c
            fc_func_act #(
                .DATA_SIZE      (DATA_SIZE),
                .OBUF_DATA_SIZE (OBUF_DATA_SIZE),
                .V_CIM_TILES    (V_CIM_TILES),
                .ACC_W          (ACC_W)
            ) u_act (
                .i_data  (i_data[h][c]),
                .i_shift (shift_q),
                .o_act   (act_s[h][c])
            );
        end
    end

    // Channels past the end of the tile are masked off and forced to zero.
    always_comb begin
        wmask_d = '0;
        data_d  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wmask_d[c] = ((int'(cap_addr_s) * NUM_CHANNELS + c) < ELEMENTS_PER_TILE);
        end
        for (int h = 0; h < H_CIM_TILES; h++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (wmask_d[c]) begin
                    data_d[h][c] = act_s[h][c];
                end else begin
                    data_d[h][c] = '0;
                end
            end
        end
    end

    // Sweep control: accept or park a start, issue every address, drain, pulse start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            shift_q <= '0;
            addr_q  <= '0;
            ready_q <= 1'b1;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start && i_cim_ready && i_next_ready) begin
                        shift_q <= i_shift;
                        addr_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_ISSUE;
                    end else if (i_start) begin
                        pend_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (pend_q && i_cim_ready && i_next_ready) begin
                        shift_q <= i_shift;
                        addr_q  <= '0;
                        pend_q  <= 1'b0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (addr_q == AW'(NUM_ADDR - 1)) begin
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!inflight_s) begin
                        start_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    pend_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output write register; address, mask and data hold between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wmask_q <= '0;
            data_q  <= '0;
        end else if (cap_vld_s) begin
            we_q    <= 1'b1;
            waddr_q <= cap_addr_s;
            wmask_q <= wmask_d;
            data_q  <= data_d;
        end else begin
            we_q    <= 1'b0;
        end
    end

    assign o_ready        = ready_q;
    assign o_addr         = addr_q;
    assign o_start        = start_q;
    assign o_write_enable = we_q;
    assign o_waddr        = waddr_q;
    assign o_wmask        = wmask_q;
    assign o_data         = data_q;

endmodule
